alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one `alu` instance between two requesters using round-robin arbitration. Each requester has a valid/ready request channel for operands and control, and a valid/ready response channel for the result and carry. The arbiter registers the ALU result and routes it back to the requester that issued the operation. It sits between the two operand producers (for example, an execute stage and an address-generation unit) and the shared ALU datapath.

## Interface
- `N`, default 64: operand and result width; passed unchanged to the internal `alu #(N)`.

- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_req_valid` in 2: request valid; bit k belongs to requester k.
- `o_req_ready` out 2: request accepted this cycle; one-hot or zero.
- `i_a` in 2*N: first operands; requester k at `[k*N +: N]`.
- `i_b` in 2*N: second operands, same packing as `i_a`.
- `i_alu_ctrl` in 4: ALU control; requester k at `[2k +: 2]`. Encoding: 00 add, 01 sub, 10 and, 11 or.
- `o_rsp_valid` out 2: response valid; at most one bit set.
- `i_rsp_ready` in 2: response accepted by requester k.
- `o_result` out N: registered ALU result; shared by both requesters and qualified by `o_rsp_valid`.
- `o_carry_out` out 1: registered ALU carry out, qualified by `o_rsp_valid`.

## Operation
- **State:**
  - `r_pending`: a response is held.
  - `r_owner`: requester id of the held response.
  - `r_result`, `r_carry`: held response data.
  - `r_prio`: requester holding priority, 0 or 1.
- **Acceptance:** `can_accept = !r_pending | (i_rsp_ready[r_owner])`. A new request may be granted in the same cycle the held response drains.
- **Grant:**
  - Both valid: grant requester `r_prio`.
  - One valid: grant that requester.
  - None valid: no grant.
  - `o_req_ready[k] = can_accept & grant[k]`. This is combinational from `i_req_valid` and is the only path from request valid to ready.
- **On a granted cycle:**
  - Operands and ctrl of the granted requester are muxed into `alu`.
  - On the next edge: `r_result`/`r_carry` capture the ALU outputs, `r_owner` is set to the granted id, `r_pending` is set to 1, and `r_prio` is set to the other requester (`~grant id`).
- **Priority stability:** `r_prio` changes only on a grant. With both requesters continuously valid, grants strictly alternate, so neither requester starves.
- **Drain with no new grant:** `r_pending` is set to 0.
- **Held response:** `r_result`, `r_carry` and `r_owner` stay stable while `r_pending=1` and `i_rsp_ready[r_owner]=0`.
- **Response outputs:** `o_rsp_valid[k] = r_pending & (r_owner==k)`. `o_result` and `o_carry_out` are driven from `r_result` and `r_carry`.
- **Ignored inputs:** `i_rsp_ready` of the non-owner is ignored.
- **Arithmetic:** defined entirely by `alu`.
  - Sub computes a + ~b + 1; carry=1 means no borrow.
  - For and/or, `o_carry_out` is the carry of a+b, passed through unchanged.

## Timing
- **Reset values** (asynchronous, while `i_rst_n=0`):
  - `r_pending=0`, so `o_rsp_valid=2'b00`.
  - `o_result=0`, `o_carry_out=0`, `r_owner=0`, `r_prio=0`.
  - `o_req_ready=2'b00`.
- **Latency:** request handshake in cycle t, response valid in cycle t+1.
- **Throughput:** one operation per cycle when the owner holds `i_rsp_ready=1`.
- **Backpressure:** while a response is held and not accepted, `o_req_ready=2'b00`. Requester valids must stay asserted; operands may change, and only the values present in the grant cycle are used.
- **Simultaneous events:** a response drains and a new grant happens in the same cycle. `o_rsp_valid` then moves to the new owner on the next edge with no bubble. If the new owner is the same requester, `o_rsp_valid` stays high with new data.
- **Reset mid-operation:** a held response is discarded without being delivered, and `r_prio` returns to 0.

## Test plan
- **Reset:** assert `i_rst_n=0` mid-stream with a response pending → `o_rsp_valid=00`, `o_result=0`, `o_carry_out=0` immediately. First grant after release goes to requester 0 when both are valid.
- **Single requester:**
  - Requester 0 sub a=5, b=3 → next cycle `o_rsp_valid=01`, result 2, carry 1.
  - Then a=3, b=5 → result 0xFFFF_FFFF_FFFF_FFFE, carry 0.
- **Contention:** both valid every cycle, `i_rsp_ready=11`. Requester 0 add 0xFFFF_FFFF_FFFF_FFFF+1; requester 1 or 0xF0|0x0F. Required:
  - Grants alternate 0,1,0,1.
  - Responses: result 0 carry 1, then result 0xFF carry 0.
  - One response per cycle.
- **Backpressure:** requester 1 holds `i_rsp_ready[1]=0` for 3 cycles while requester 0 is valid → `o_req_ready=00` and the response is stable for those cycles. In the cycle `i_rsp_ready[1]` rises, `o_req_ready=01`, and the requester 0 response appears next cycle.
- **And op:** a=0xFF00, b=0x0FF0, ctrl 10 → result 0x0F00, carry 0.
- **Priority stability:** only requester 1 valid for 2 grants, then both valid → requester 0 is granted, because `r_prio` became 0 after requester 1's grant.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two operand producers and the shared ALU arbiter.
// Requester k owns bit k of each 2-bit field and slice k of each packed operand bus.
interface alu_arbiter_if #(
    parameter int N = 64
);
    logic [1:0]     i_req_valid;
    logic [1:0]     o_req_ready;
    logic [2*N-1:0] i_a;
    logic [2*N-1:0] i_b;
    logic [3:0]     i_alu_ctrl;
    logic [1:0]     o_rsp_valid;
    logic [1:0]     i_rsp_ready;
    logic [N-1:0]   o_result;
    logic           o_carry_out;

    // Requester side: drives operands and response acceptance.
    modport master (
        output i_req_valid, i_a, i_b, i_alu_ctrl, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_result, o_carry_out
    );

    // Arbiter side.
    modport slave (
        input  i_req_valid, i_a, i_b, i_alu_ctrl, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_result, o_carry_out
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters, with a
// one-entry registered response routed back to the requester that issued it.

module alu #(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   alu_ctrl,
    output logic [N-1:0] result,
    output logic         carry_out
);
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    alu_op_e      op;
    logic [N:0]   sum_add;
    logic [N:0]   sum_sub;

    assign op      = alu_op_e'(alu_ctrl);
    assign sum_add = {1'b0, a} + {1'b0, b};
    // Subtract as a + ~b + 1 so carry=1 means no borrow.
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        result    = sum_add[N-1:0];
        carry_out = sum_add[N];
        unique case (op)
            OP_ADD: begin
                result    = sum_add[N-1:0];
                carry_out = sum_add[N];
            end
            OP_SUB: begin
                result    = sum_sub[N-1:0];
                carry_out = sum_sub[N];
            end
            // Logic ops pass the adder carry through unchanged.
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            default: ;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int N = 64
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    alu_arbiter_if.slave  bus
);
    logic         r_pending;
    logic         r_owner;
    logic [N-1:0] r_result;
    logic         r_carry;
    logic         r_prio;

    logic         can_accept;
    logic         grant_valid;
    logic         grant_id;
    logic [1:0]   ready;
    logic         take;
    logic         drain;

    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [1:0]   alu_op;
    logic [N-1:0] alu_result;
    logic         alu_carry;

    // Grant selection is purely combinational from the request valids.
    always_comb begin
        grant_valid = |bus.i_req_valid;
        grant_id    = 1'b0;
        case (bus.i_req_valid)
            2'b11:   grant_id = r_prio;
            2'b10:   grant_id = 1'b1;
            default: grant_id = 1'b0;
        endcase

        can_accept = !r_pending || bus.i_rsp_ready[r_owner];

        // Ready is held low throughout reset even though the core looks idle.
        ready = 2'b00;
        if (can_accept && grant_valid && i_rst_n) begin
            ready[grant_id] = 1'b1;
        end
    end

    assign take  = |ready;
    assign drain = r_pending && bus.i_rsp_ready[r_owner];

    assign alu_a  = grant_id ? bus.i_a[N +: N] : bus.i_a[0 +: N];
    assign alu_b  = grant_id ? bus.i_b[N +: N] : bus.i_b[0 +: N];
    assign alu_op = grant_id ? bus.i_alu_ctrl[3:2] : bus.i_alu_ctrl[1:0];

    alu #(.N(N)) u_alu (
        .a         (alu_a),
        .b         (alu_b),
        .alu_ctrl  (alu_op),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: the result register is reset too, because its value is visible on o_result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= 1'b0;
            r_owner   <= 1'b0;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_prio    <= 1'b0;
        end else if (take) begin
            r_pending <= 1'b1;
            r_owner   <= grant_id;
            r_result  <= alu_result;
            r_carry   <= alu_carry;
            r_prio    <= ~grant_id;
        end else if (drain) begin
            r_pending <= 1'b0;
        end
    end

    assign bus.o_req_ready = ready;
    assign bus.o_rsp_valid = {r_pending & r_owner, r_pending & ~r_owner};
    assign bus.o_result    = r_result;
    assign bus.o_carry_out = r_carry;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single requester, contention,
// backpressure, logic ops, priority stability and reset mid-operation.
module tb_alu_arbiter;
    localparam int W = 64;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    alu_arbiter_if #(.N(W)) bus ();

    alu_arbiter #(.N(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] ctrl);
        bus.i_a[k*W +: W]      = a;
        bus.i_b[k*W +: W]      = b;
        bus.i_alu_ctrl[2*k +: 2] = ctrl;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.i_req_valid = 2'b00;
        bus.i_rsp_ready = 2'b00;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.i_req_valid = 2'b11;
        bus.i_rsp_ready = 2'b11;
        set_req(0, 64'd1, 64'd1, 2'b00);
        set_req(1, 64'd2, 64'd2, 2'b00);
        #2;
        checks++; if (bus.o_rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", bus.o_rsp_valid); end
        checks++; if (bus.o_result !== 64'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.o_result); end
        checks++; if (bus.o_carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b exp=0", bus.o_carry_out); end
        checks++; if (bus.o_req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", bus.o_req_ready); end
        tick();
        checks++; if (bus.o_rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_hold_rsp_valid got=%b exp=00", bus.o_rsp_valid); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.o_req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant got=%b exp=01", bus.o_req_ready); end
        tick();
        checks++; if (bus.o_rsp_valid !== 2'b01) begin errors++; $display("FAIL reset_first_rsp got=%b exp=01", bus.o_rsp_valid); end
        checks++; if (bus.o_result !== 64'd2) begin errors++; $display("FAIL reset_first_result got=%h exp=2", bus.o_result); end
        checks++; if (bus.o_req_ready !== 2'b10) begin errors++; $display("FAIL reset_second_grant got=%b exp=10", bus.o_req_ready); end
        bus.i_req_valid = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_single();
        bus.i_rsp_ready = 2'b11;
        bus.i_req_valid = 2'b01;
        set_req(0, 64'd5, 64'd3, 2'b01);
        #1;
        checks++; if (bus.o_req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", bus.o_req_ready); end
        tick();
        set_req(0, 64'd3, 64'd5, 2'b01);
        checks++; if (bus.o_rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got=%b exp=01", bus.o_rsp_valid); end
        checks++; if (bus.o_result !== 64'd2) begin errors++; $display("FAIL single_sub_result got=%h exp=2", bus.o_result); end
        checks++; if (bus.o_carry_out !== 1'b1) begin errors++; $display("FAIL single_sub_carry got=%b exp=1", bus.o_carry_out); end
        tick();
        bus.i_req_valid = 2'b00;
        checks++; if (bus.o_rsp_valid !== 2'b01) begin errors++; $display("FAIL single_no_bubble got=%b exp=01", bus.o_rsp_valid); end
        checks++; if (bus.o_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL single_borrow_result got=%h exp=fffffffffffffffe", bus.o_result); end
        checks++; if (bus.o_carry_out !== 1'b0) begin errors++; $display("FAIL single_borrow_carry got=%b exp=0", bus.o_carry_out); end
        tick();
        checks++; if (bus.o_rsp_valid !== 2'b00) begin errors++; $display("FAIL single_drain got=%b exp=00", bus.o_rsp_valid); end
    endtask

    task automatic test_contention();
        logic [1:0]   exp_grant [4];
        exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        bus.i_rsp_ready = 2'b11;
        bus.i_req_valid = 2'b11;
        set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00);
        set_req(1, 64'hF0, 64'h0F, 2'b11);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.o_req_ready !== exp_grant[i]) begin errors++; $display("FAIL contention_grant[%0d] got=%b exp=%b", i, bus.o_req_ready, exp_grant[i]); end
            tick();
            checks++; if (bus.o_rsp_valid !== exp_grant[i]) begin errors++; $display("FAIL contention_rsp[%0d] got=%b exp=%b", i, bus.o_rsp_valid, exp_grant[i]); end
            if (exp_grant[i] == 2'b01) begin
                checks++; if (bus.o_result !== 64'd0 || bus.o_carry_out !== 1'b1) begin errors++; $display("FAIL contention_add[%0d] got=%h/%b exp=0/1", i, bus.o_result, bus.o_carry_out); end
            end else begin
                checks++; if (bus.o_result !== 64'hFF || bus.o_carry_out !== 1'b0) begin errors++; $display("FAIL contention_or[%0d] got=%h/%b exp=ff/0", i, bus.o_result, bus.o_carry_out); end
            end
        end
        bus.i_req_valid = 2'b00;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.i_rsp_ready = 2'b01;
        bus.i_req_valid = 2'b10;
        set_req(1, 64'd7, 64'd1, 2'b00);
        #1;
        checks++; if (bus.o_req_ready !== 2'b10) begin errors++; $display("FAIL bp_initial_grant got=%b exp=10", bus.o_req_ready); end
        tick();
        bus.i_req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            set_req(0, 64'hDEAD_0000 + 64'(i), 64'h1234, 2'b00);
            #1;
            checks++; if (bus.o_req_ready !== 2'b00) begin errors++; $display("FAIL bp_stall_ready[%0d] got=%b exp=00", i, bus.o_req_ready); end
            checks++; if (bus.o_rsp_valid !== 2'b10 || bus.o_result !== 64'd8) begin errors++; $display("FAIL bp_stall_hold[%0d] got=%b/%h exp=10/8", i, bus.o_rsp_valid, bus.o_result); end
            tick();
        end
        set_req(0, 64'h10, 64'h20, 2'b00);
        bus.i_rsp_ready = 2'b11;
        #1;
        checks++; if (bus.o_req_ready !== 2'b01) begin errors++; $display("FAIL bp_release_ready got=%b exp=01", bus.o_req_ready); end
        tick();
        bus.i_req_valid = 2'b00;
        checks++; if (bus.o_rsp_valid !== 2'b01 || bus.o_result !== 64'h30) begin errors++; $display("FAIL bp_release_rsp got=%b/%h exp=01/30", bus.o_rsp_valid, bus.o_result); end
        tick();
    endtask

    task automatic test_logic_ops();
        bus.i_rsp_ready = 2'b11;
        bus.i_req_valid = 2'b01;
        set_req(0, 64'hFF00, 64'h0FF0, 2'b10);
        tick();
        set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b10);
        checks++; if (bus.o_result !== 64'h0F00 || bus.o_carry_out !== 1'b0) begin errors++; $display("FAIL and_basic got=%h/%b exp=0f00/0", bus.o_result, bus.o_carry_out); end
        tick();
        set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b11);
        checks++; if (bus.o_result !== 64'd1 || bus.o_carry_out !== 1'b1) begin errors++; $display("FAIL and_carry_pass got=%h/%b exp=1/1", bus.o_result, bus.o_carry_out); end
        tick();
        bus.i_req_valid = 2'b00;
        checks++; if (bus.o_result !== 64'hFFFF_FFFF_FFFF_FFFF || bus.o_carry_out !== 1'b1) begin errors++; $display("FAIL or_carry_pass got=%h/%b exp=ffffffffffffffff/1", bus.o_result, bus.o_carry_out); end
        tick();
    endtask

    task automatic test_priority();
        do_reset();
        bus.i_rsp_ready = 2'b11;
        bus.i_req_valid = 2'b10;
        set_req(0, 64'd100, 64'd1, 2'b00);
        set_req(1, 64'd200, 64'd1, 2'b00);
        #1;
        checks++; if (bus.o_req_ready !== 2'b10) begin errors++; $display("FAIL prio_r1_first got=%b exp=10", bus.o_req_ready); end
        tick();
        checks++; if (bus.o_req_ready !== 2'b10) begin errors++; $display("FAIL prio_r1_second got=%b exp=10", bus.o_req_ready); end
        tick();
        bus.i_req_valid = 2'b11;
        #1;
        checks++; if (bus.o_req_ready !== 2'b01) begin errors++; $display("FAIL prio_r0_after got=%b exp=01", bus.o_req_ready); end
        tick();
        checks++; if (bus.o_rsp_valid !== 2'b01 || bus.o_result !== 64'd101) begin errors++; $display("FAIL prio_r0_rsp got=%b/%h exp=01/65", bus.o_rsp_valid, bus.o_result); end
        checks++; if (bus.o_req_ready !== 2'b10) begin errors++; $display("FAIL prio_alternate got=%b exp=10", bus.o_req_ready); end
        bus.i_req_valid = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        bus.i_rsp_ready = 2'b00;
        bus.i_req_valid = 2'b01;
        set_req(0, 64'd9, 64'd1, 2'b00);
        set_req(1, 64'd50, 64'd50, 2'b00);
        tick();
        checks++; if (bus.o_rsp_valid !== 2'b01 || bus.o_result !== 64'd10) begin errors++; $display("FAIL mid_pending got=%b/%h exp=01/a", bus.o_rsp_valid, bus.o_result); end
        bus.i_req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_rsp_valid !== 2'b00) begin errors++; $display("FAIL mid_rsp_valid got=%b exp=00", bus.o_rsp_valid); end
        checks++; if (bus.o_result !== 64'd0 || bus.o_carry_out !== 1'b0) begin errors++; $display("FAIL mid_data got=%h/%b exp=0/0", bus.o_result, bus.o_carry_out); end
        checks++; if (bus.o_req_ready !== 2'b00) begin errors++; $display("FAIL mid_req_ready got=%b exp=00", bus.o_req_ready); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (bus.o_req_ready !== 2'b01) begin errors++; $display("FAIL mid_prio_cleared got=%b exp=01", bus.o_req_ready); end
        tick();
        checks++; if (bus.o_rsp_valid !== 2'b01 || bus.o_result !== 64'd10) begin errors++; $display("FAIL mid_after_rsp got=%b/%h exp=01/a", bus.o_rsp_valid, bus.o_result); end
        bus.i_req_valid = 2'b00;
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        rst_n           = 1'b0;
        bus.i_req_valid = 2'b00;
        bus.i_rsp_ready = 2'b00;
        bus.i_a         = '0;
        bus.i_b         = '0;
        bus.i_alu_ctrl  = '0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_logic_ops();
        test_priority();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
